// File: rtl/vga_pkg.sv
// Shared VGA definitions: raster timing, pixel/colour types and the sprite key colour.
package vga_pkg;
  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
  localparam int HOR_TOTAL  = 1056;
  localparam int VER_TOTAL  = 628;
  localparam int CNT_W      = 11;
  localparam int RGB_W      = 12;

  typedef logic [RGB_W-1:0] rgb_t;

  localparam rgb_t SPRITE_KEY = 12'hf08;

  typedef struct packed {
    logic [CNT_W-1:0] vcount;
    logic [CNT_W-1:0] hcount;
    logic             vsync;
    logic             hsync;
    logic             vblnk;
    logic             hblnk;
    rgb_t             rgb;
  } vga_t;
endpackage

// File: rtl/vga_if.sv
// VGA timing + colour stream bundle passed between draw stages.
interface vga_if;
  import vga_pkg::*;
  logic [CNT_W-1:0] vcount;
  logic [CNT_W-1:0] hcount;
  logic             vsync;
  logic             hsync;
  logic             vblnk;
  logic             hblnk;
  rgb_t             rgb;

  modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/draw_anim_sprite_frame_ctr.sv
// Animation pacing: counts vsync rising edges and steps the frame index every FRAME_DIV of them.
module anim_frame_ctr #(
  parameter  int FRAMES    = 3,
  parameter  int FRAME_DIV = 8,
  localparam int FW        = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int DW        = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          run,
  output logic [FW-1:0] frame_idx
);
  logic          vsync_d;
  logic [DW-1:0] div_cnt;

  // Edge tracking keeps running while paused so resuming never sees a stale edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_d   <= 1'b0;
      div_cnt   <= '0;
      frame_idx <= '0;
    end else begin
      vsync_d <= vsync;
      if (run && vsync && !vsync_d) begin
        if (div_cnt == DW'(FRAME_DIV - 1)) begin
          div_cnt   <= '0;
          frame_idx <= (frame_idx == FW'(FRAMES - 1)) ? '0 : frame_idx + 1'b1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/draw_anim_sprite.sv
// Scaled, optionally mirrored, animated sprite overlay with colour-key transparency; 3-clk pipeline.
module draw_anim_sprite
  import vga_pkg::*;
#(
  parameter  int   WIDTH     = 55,
  parameter  int   HEIGHT    = 48,
  parameter  int   SIZE      = 1,
  parameter  int   FRAMES    = 3,
  parameter  int   FRAME_DIV = 8,
  parameter  rgb_t KEY_RGB   = SPRITE_KEY,
  localparam int   ADDR_W    = $clog2(WIDTH*HEIGHT*FRAMES),
  localparam int   FW        = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  vga_if.in                 in,
  vga_if.out                out,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic              enable,
  input  logic              flip_h,
  input  logic              anim_run,
  output logic [ADDR_W-1:0] pixel_addr,
  input  rgb_t              rgb_pixel,
  output logic [FW-1:0]     frame_idx
);
  localparam logic [12:0] SPAN_X = 13'(WIDTH << SIZE);
  localparam logic [12:0] SPAN_Y = 13'(HEIGHT << SIZE);
  localparam int          FSZ    = WIDTH * HEIGHT;

  vga_t        cur;
  vga_t [2:1]  stg;
  logic [2:1]  hit_pipe;
  logic [11:0] xs, ys;
  logic        en_s, flip_s, vblnk_d;
  logic        latch, hit0;
  logic [12:0] h13, v13, x13, y13, col, lcol, row;

  anim_frame_ctr #(.FRAMES(FRAMES), .FRAME_DIV(FRAME_DIV)) u_anim (
    .clk       (clk),
    .rst       (rst),
    .vsync     (in.vsync),
    .run       (anim_run),
    .frame_idx (frame_idx)
  );

  assign cur   = {in.vcount, in.hcount, in.vsync, in.hsync, in.vblnk, in.hblnk, in.rgb};
  assign latch = in.vblnk && !vblnk_d && (in.vcount != '0);

  // 13-bit compares so a sprite hanging off the right/bottom edge never wraps.
  assign h13  = {2'b0, in.hcount};
  assign v13  = {2'b0, in.vcount};
  assign x13  = {1'b0, xs};
  assign y13  = {1'b0, ys};
  assign hit0 = en_s && !(in.vblnk || in.hblnk) &&
                (h13 >= x13) && (h13 < x13 + SPAN_X) &&
                (v13 >= y13) && (v13 < y13 + SPAN_Y);
  assign col  = (h13 - x13) >> SIZE;
  assign row  = (v13 - y13) >> SIZE;
  assign lcol = flip_s ? col : 13'(WIDTH - 1) - col;

  // pixel_addr is the stage-1 register; the ROM answers in step with stage 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_d    <= 1'b0;
      xs         <= '0;
      ys         <= '0;
      en_s       <= 1'b0;
      flip_s     <= 1'b0;
      stg        <= '0;
      hit_pipe   <= '0;
      pixel_addr <= '0;
      out.vcount <= '0;
      out.hcount <= '0;
      out.vsync  <= 1'b0;
      out.hsync  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      vblnk_d <= in.vblnk;
      if (latch) begin
        xs     <= xpos;
        ys     <= ypos;
        en_s   <= enable;
        flip_s <= flip_h;
      end
      stg        <= {stg[1], cur};
      hit_pipe   <= {hit_pipe[1], hit0};
      pixel_addr <= hit0 ? ADDR_W'(FSZ*int'(frame_idx) + WIDTH*int'(row) + int'(lcol)) : '0;
      out.vcount <= stg[2].vcount;
      out.hcount <= stg[2].hcount;
      out.vsync  <= stg[2].vsync;
      out.hsync  <= stg[2].hsync;
      out.vblnk  <= stg[2].vblnk;
      out.hblnk  <= stg[2].hblnk;
      if (stg[2].vblnk || stg[2].hblnk)
        out.rgb <= '0;
      else if (hit_pipe[2] && rgb_pixel != KEY_RGB)
        out.rgb <= rgb_pixel;
      else
        out.rgb <= stg[2].rgb;
    end
  end
endmodule

// File: doc/draw_anim_sprite.md
DRAW_ANIM_SPRITE -- requirements
Module: draw_anim_sprite

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
  WIDTH, 55, sprite width in source pixels.
  HEIGHT, 48, sprite height in source pixels.
  SIZE, 1, scale shift; each source pixel covers a (1<<SIZE) x (1<<SIZE) screen block.
  FRAMES, 3, number of animation frames stored consecutively in the ROM.
  FRAME_DIV, 8, number of video frames each animation frame is held.
  KEY_RGB, 12'hf08, transparent colour.
REQ-002 Derived constant: ADDR_W = clog2(WIDTH*HEIGHT*FRAMES).
REQ-003 Ports SHALL be, one per line, as name, direction, width, meaning:
  clk, in, 1, pixel clock.
  rst, in, 1, asynchronous, active-low reset.
  in, vga_if.in, -, timing and background stream.
  out, vga_if.out, -, timing and composited stream.
  xpos, in, 12, requested sprite left edge.
  ypos, in, 12, requested sprite top edge.
  enable, in, 1, sprite visible.
  flip_h, in, 1, mirror horizontally when 1.
  anim_run, in, 1, animation advances when 1.
  pixel_addr, out, ADDR_W, ROM address.
  rgb_pixel, in, 12, ROM data, valid one clk after pixel_addr.
  frame_idx, out, clog2(FRAMES), current animation frame.

Function
REQ-004 Total latency from in to out SHALL be 3 clk for all timing signals (vcount, hcount, vsync, hsync, vblnk, hblnk); rgb SHALL be aligned to the same cycle.
REQ-005 pixel_addr SHALL be registered, computed from stage-1 counters, so that rgb_pixel arrives aligned with stage 2.
REQ-006 xpos, ypos, enable and flip_h SHALL be latched into shadow registers only on the rising edge of in.vblnk while in.vcount != 0; they SHALL be stable for a whole visible frame (no tearing).
REQ-007 Hit SHALL be true when hcount is in [xs, xs + (WIDTH<<SIZE)) and vcount is in [ys, ys + (HEIGHT<<SIZE)), enable_s=1, and the pixel is not blanked; comparisons SHALL use 13-bit sums so there is no wrap at the screen edge.
REQ-008 Local column: c = (hcount-xs)>>SIZE; lc = flip_h_s ? c : WIDTH-1-c.
REQ-009 pixel_addr SHALL be frame_idx*WIDTH*HEIGHT + ((vcount-ys)>>SIZE)*WIDTH + lc on hit, else 0.
REQ-010 Output rgb SHALL be: 0 when blanked; rgb_pixel when hit and rgb_pixel != KEY_RGB; otherwise the background rgb.
REQ-011 Divider counter div_cnt SHALL count in.vsync rising edges 0..FRAME_DIV-1 while anim_run=1, and hold while anim_run=0.
REQ-012 On div_cnt wrap, frame_idx SHALL advance; FRAMES-1 wraps to 0.
REQ-013 frame_idx SHALL update only at a vsync edge, never mid-frame; its effect on pixel_addr SHALL be visible from the next visible line.
REQ-014 anim_run falling SHALL freeze frame_idx and div_cnt; rising SHALL resume from the held values.
REQ-015 When a vsync edge and a vblnk edge occur in the same cycle, both updates SHALL take effect independently.
REQ-016 FRAMES=1 SHALL hold frame_idx=0 permanently.

Reset
REQ-017 While rst=0, all pipeline registers, out.* signals, pixel_addr, frame_idx, div_cnt, shadow registers and edge-detect registers SHALL be 0, asynchronously.
REQ-018 After reset release, the sprite SHALL be hidden until the first latched vblnk edge; out SHALL be valid 3 clk after the first input.

Structure
REQ-019 The vga_if timing constants and the 12-bit RGB type SHALL reside in the shared vga package; KEY_RGB default SHALL be defined there as SPRITE_KEY.
REQ-020 The animation divider and frame counter SHALL be a sub-module anim_frame_ctr (inputs: clk, rst, vsync, run; output: frame_idx).

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
  Static sprite: xpos=100, ypos=200, enable=1, flip_h=0, ROM data = address. The pixel at (100,200) gives pixel_addr=54, and out.rgb appears 3 clk after that pixel enters.
  Flip: flip_h=1, same position. The pixel at (100,200) gives pixel_addr=0, and (209,200) gives 54.
  Transparency: ROM returns 12'hf08 at one address. out.rgb equals the background rgb there; all other hit pixels show ROM data.
  Animation: anim_run=1, FRAME_DIV=2, FRAMES=3. frame_idx goes 0,0,1,1,2,2,0 over 7 vsyncs, and the frame 1 base address is 2640.
  Mid-frame move: xpos changes at vcount=300. The sprite position is unchanged until the next vblnk, then moves.
  Reset mid-frame: rst=0 at hcount=400. All outputs go 0 immediately; after release, no sprite appears before the first vblnk latch.
